// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit 7-segment driver.
// Shows hex nibbles directly, or converts an unsigned binary value to decimal
// with a sequential double-dabble (one input bit per cycle). Supports per-digit
// decimal points, leading-zero blanking, overflow dashes and pin polarity.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int DIV_BITS       = 17,
   parameter int AN_ACTIVE_LOW  = 0,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   input  logic                    wr_mode,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic                    busy,
   output logic                    ovf,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp
);
   localparam int W          = 4 * NUM_DIGITS;
   // Scratch carries extra BCD digits so values beyond the display range
   // leave nonzero digits above the visible ones (overflow detection).
   localparam int BCD_DIGITS = NUM_DIGITS + (NUM_DIGITS + 3) / 4;
   localparam int BW         = 4 * BCD_DIGITS;
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W      = $clog2(W + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CONV = 1'b1;

   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

   logic [0:0]            state_q, state_d;
   logic [DIV_BITS-1:0]   div_q, div_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [W-1:0]          disp_q, disp_d;
   logic [NUM_DIGITS-1:0] dp_mask_q, dp_mask_d;
   logic                  ovf_q, ovf_d;
   logic [W-1:0]          bin_q, bin_d;
   logic [BW-1:0]         bcd_q, bcd_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic [BW-1:0]         bcd_adj;
   logic [BW-1:0]         bcd_shift;
   logic [NUM_DIGITS-1:0] zero_up;

   function automatic logic [6:0] font(input logic [3:0] v);
      case (v)
         4'h0: font = 7'b1111110;
         4'h1: font = 7'b0110000;
         4'h2: font = 7'b1101101;
         4'h3: font = 7'b1111001;
         4'h4: font = 7'b0110011;
         4'h5: font = 7'b1011011;
         4'h6: font = 7'b1011111;
         4'h7: font = 7'b1110000;
         4'h8: font = 7'b1111111;
         4'h9: font = 7'b1110011;
         4'hA: font = 7'b1110111;
         4'hB: font = 7'b0011111;
         4'hC: font = 7'b1001110;
         4'hD: font = 7'b0111101;
         4'hE: font = 7'b1101111;
         default: font = 7'b1000111;
      endcase
   endfunction

   // Double-dabble step: add 3 to every BCD digit >= 5, then shift in next MSB.
   genvar gi;
   generate
      for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
         assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                     bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
      end
   endgenerate
   assign bcd_shift = {bcd_adj[BW-2:0], bin_q[W-1]};

   // zero_up[i] = digit i and every digit above it are zero.
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
         if (gi == NUM_DIGITS - 1) begin : g_top
            assign zero_up[gi] = (disp_q[4*gi +: 4] == 4'd0);
         end else begin : g_mid
            assign zero_up[gi] = (disp_q[4*gi +: 4] == 4'd0) && zero_up[gi+1];
         end
      end
   endgenerate

   // Write acceptance and conversion FSM; display/ovf change atomically at the end.
   always_comb begin
      state_d   = state_q;
      disp_d    = disp_q;
      dp_mask_d = dp_mask_q;
      ovf_d     = ovf_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_en) begin
               dp_mask_d = dp_in;
               if (wr_mode) begin
                  state_d = ST_CONV;
                  bin_d   = wr_data;
                  bcd_d   = '0;
                  cnt_d   = '0;
               end else begin
                  disp_d = wr_data;
                  ovf_d  = 1'b0;
               end
            end
         end
         default: begin
            bin_d = bin_q << 1;
            bcd_d = bcd_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d = ST_IDLE;
               disp_d  = bcd_shift[W-1:0];
               // A carry out of the scratch top digit also means out of range.
               ovf_d   = (|bcd_shift[BW-1:W]) | bcd_adj[BW-1];
            end
         end
      endcase
   end

   // Refresh divider and digit index; index advances when the divider wraps.
   always_comb begin
      div_d = div_q + 1'b1;
      idx_d = idx_q;
      if (div_q == '1) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Next pin values for the selected digit, polarity applied last.
   always_comb begin
      logic [3:0]            nib;
      logic [NUM_DIGITS-1:0] an_raw;
      logic [6:0]            seg_raw;
      nib    = disp_q[{idx_q, 2'b00} +: 4];
      an_raw = '0;
      an_raw[idx_q] = 1'b1;
      if (ovf_q) begin
         seg_raw = 7'b0000001;
      end else if (blank_lz && (idx_q != '0) && zero_up[idx_q]) begin
         seg_raw = 7'b0000000;
      end else begin
         seg_raw = font(nib);
      end
      an_d  = (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_mask_q[idx_q] : dp_mask_q[idx_q];
   end

   // State registers with synchronous reset; reset also aborts a conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         idx_q     <= '0;
         disp_q    <= '0;
         dp_mask_q <= '0;
         ovf_q     <= 1'b0;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         an_q      <= AN_OFF;
         seg_q     <= SEG_OFF;
         dp_q      <= DP_OFF;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         disp_q    <= disp_d;
         dp_mask_q <= dp_mask_d;
         ovf_q     <= ovf_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign busy = (state_q == ST_CONV);
   assign ovf  = ovf_q;
   assign an   = an_q;
   assign seg  = seg_q;
   assign dp   = dp_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed testbench for seg7_scan_ctrl (4 digits, 4-cycle digit dwell).
module tb_seg7_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        wr_mode;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        busy;
   logic        ovf;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;   // edges since reset release

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .NUM_DIGITS(4), .DIV_BITS(2), .AN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_mode(wr_mode),
      .dp_in(dp_in), .blank_lz(blank_lz), .busy(busy), .ovf(ovf),
      .an(an), .seg(seg), .dp(dp)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      ncyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Check n consecutive cycles of scanning against the expected digit faces.
   task automatic show(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                       input logic [6:0] s0, input logic [3:0] dpm, input int n, input string tag);
      logic [6:0] es[4];
      es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
      $display("scan %s: %0d cycles", tag, n);
      for (int k = 0; k < n; k++) begin
         int d;
         d = ((ncyc - 1) / 4) % 4;
         chk({tag, "_an"}, {28'b0, an}, 32'(1 << d));
         chk({tag, "_seg"}, {25'b0, seg}, {25'b0, es[d]});
         chk({tag, "_dp"}, 32'(dp), 32'(dpm[d]));
         tick();
      end
   endtask

   task automatic write(input logic mode, input logic [15:0] data, input logic [3:0] dpm);
      $display("write mode=%0d data=%h dp=%b", mode, data, dpm);
      wr_en = 1'b1; wr_mode = mode; wr_data = data; dp_in = dpm;
      tick();
      wr_en = 1'b0;
   endtask

   localparam logic [6:0] F0 = 7'b1111110;
   localparam logic [6:0] DASH = 7'b0000001;

   initial begin
      logic [6:0] old_seg[4];
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_mode = 1'b0; dp_in = '0; blank_lz = 1'b0;

      // 1: reset state, then digit 0 selected first cycle after release
      repeat (3) tick();
      chk("rst_an", {28'b0, an}, 32'h0);
      chk("rst_seg", {25'b0, seg}, 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      rst = 1'b0;
      ncyc = 0;
      tick();
      chk("rel_an", {28'b0, an}, 32'h1);
      chk("rel_seg", {25'b0, seg}, 32'b1111110);
      show(F0, F0, F0, F0, 4'b0000, 8, "t1");

      // 2: hex write with a decimal point on digit 2
      write(1'b0, 16'hA5C3, 4'b0100);
      tick();
      show(7'b1110111, 7'b1011011, 7'b1001110, 7'b1111001, 4'b0100, 20, "t2");

      // 3: decimal 1234, busy exactly 16 cycles, write during busy dropped
      old_seg[3] = 7'b1110111; old_seg[2] = 7'b1011011;
      old_seg[1] = 7'b1001110; old_seg[0] = 7'b1111001;
      write(1'b1, 16'd1234, 4'b0000);
      for (int k = 0; k < 16; k++) begin
         int d;
         d = ((ncyc - 1) / 4) % 4;
         chk("t3_busy", 32'(busy), 32'h1);
         chk("t3_hold_seg", {25'b0, seg}, {25'b0, old_seg[d]});
         if (k == 4) begin
            wr_en = 1'b1; wr_mode = 1'b0; wr_data = 16'h9999; dp_in = 4'b1111;
         end
         tick();
         wr_en = 1'b0;
      end
      chk("t3_busy_fall", 32'(busy), 32'h0);
      chk("t3_ovf", 32'(ovf), 32'h0);
      tick();
      show(7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 4'b0000, 16, "t3");

      // 4: decimal 10000 overflows -> dashes; hex write clears ovf
      write(1'b1, 16'd10000, 4'b0001);
      repeat (16) tick();
      chk("t4_busy", 32'(busy), 32'h0);
      chk("t4_ovf", 32'(ovf), 32'h1);
      tick();
      show(DASH, DASH, DASH, DASH, 4'b0001, 16, "t4a");
      write(1'b0, 16'h0001, 4'b0000);
      chk("t4_ovf_clr", 32'(ovf), 32'h0);
      tick();
      show(F0, F0, F0, 7'b0110000, 4'b0000, 16, "t4b");

      // 5: leading-zero blanking
      blank_lz = 1'b1;
      write(1'b0, 16'h0070, 4'b0000);
      tick();
      show(7'b0, 7'b0, 7'b1110000, F0, 4'b0000, 16, "t5a");
      write(1'b0, 16'h0000, 4'b0000);
      tick();
      show(7'b0, 7'b0, 7'b0, F0, 4'b0000, 16, "t5b");

      // 6: reset mid-conversion aborts the result
      blank_lz = 1'b0;
      write(1'b1, 16'd4321, 4'b0000);
      repeat (7) tick();
      chk("t6_busy_mid", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      chk("t6_busy_rst", 32'(busy), 32'h0);
      chk("t6_an_rst", {28'b0, an}, 32'h0);
      chk("t6_seg_rst", {25'b0, seg}, 32'h0);
      rst = 1'b0;
      ncyc = 0;
      tick();
      show(F0, F0, F0, F0, 4'b0000, 40, "t6");
      chk("t6_busy_end", 32'(busy), 32'h0);
      chk("t6_ovf_end", 32'(ovf), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
